// File: rtl/counter_4bit_ctrl_pkg.sv
// Shared constants and types for the push-button controlled 4-bit counter.
// The default counter width, direction codes, FSM states and debounce lengths live here.
package counter_4bit_ctrl_pkg;

  localparam int unsigned WIDTH_DEFAULT  = 4;
  localparam int unsigned DEBOUNCE_SIM   = 4;
  localparam int unsigned DEBOUNCE_BOARD = 1_000_000;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Width of a counter able to hold 0 .. cycles-1. It is never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/counter_4bit_ctrl_if.sv
// Board-facing bundle for the counter: the divided clock, the buttons and switches, and the LEDs.
// The master side drives the inputs. The slave side is the counter itself.
interface counter_4bit_ctrl_if #(
  parameter int unsigned WIDTH = counter_4bit_ctrl_pkg::WIDTH_DEFAULT
);

  logic             clk_div;
  logic             btn_run;
  logic             btn_dir;
  logic             btn_clr;
  logic             btn_load;
  logic [WIDTH-1:0] sw_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             running;
  logic             dir;

  modport master (
    output clk_div, btn_run, btn_dir, btn_clr, btn_load, sw_val,
    input  count, tc, running, dir
  );

  modport slave (
    input  clk_div, btn_run, btn_dir, btn_clr, btn_load, sw_val,
    output count, tc, running, dir
  );

endinterface

// File: rtl/counter_4bit_ctrl_button_debounce.sv
// Debounces one raw push-button: it first passes through a 2-FF synchronizer and then a stability counter.
// A debounced 0->1 transition produces a one-cycle press pulse. A release produces no pulse.
module button_debounce
  import counter_4bit_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // The level is accepted on the DEBOUNCE_CYCLES-th consecutive cycle in which it disagrees.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_4bit_ctrl.sv
// Counts the rising edges of clk_div, which is sampled as data in the clk domain.
// Debounced buttons control run/pause, direction, clear and load.
module counter_4bit_ctrl
  import counter_4bit_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = WIDTH_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_4bit_ctrl_if.slave   bus
);

  logic             s1;
  logic             s2;
  logic             s3;
  logic             step;
  logic [WIDTH-1:0] sw_s1;
  logic [WIDTH-1:0] sw_s2;
  logic [WIDTH-1:0] count_q;
  logic             tc_q;
  logic             dir_q;
  state_t           state;

  logic             press_run;
  logic             press_dir;
  logic             press_clr;
  logic             press_load;
  logic [3:0]       unused_level;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_run), .level(unused_level[0]), .press(press_run)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_dir), .level(unused_level[1]), .press(press_dir)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_clr), .level(unused_level[2]), .press(press_clr)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_load), .level(unused_level[3]), .press(press_load)
  );

  assign step = s2 & ~s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      dir_q   <= DIR_UP;
      state   <= PAUSED;
    end else begin
      s1    <= bus.clk_div;
      s2    <= s1;
      s3    <= s2;
      sw_s1 <= bus.sw_val;
      sw_s2 <= sw_s1;
      tc_q  <= 1'b0;

      // Clear and load take priority and consume a coincident step. A step uses the pre-toggle state and direction.
      if (press_clr) begin
        count_q <= '0;
      end else if (press_load) begin
        count_q <= sw_s2;
      end else if (step && state == RUNNING) begin
        if (dir_q == DIR_UP) begin
          count_q <= count_q + 1'b1;
          tc_q    <= (count_q == '1);
        end else begin
          count_q <= count_q - 1'b1;
          tc_q    <= (count_q == '0);
        end
      end

      if (press_run) begin
        state <= (state == RUNNING) ? PAUSED : RUNNING;
      end
      if (press_dir) begin
        dir_q <= ~dir_q;
      end
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = (state == RUNNING);
  assign bus.dir     = dir_q;

endmodule

// File: tb/tb_counter_4bit_ctrl.sv
// Directed bench for counter_4bit_ctrl with DEBOUNCE_CYCLES=4.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the edge or on the falling edge.
module tb_counter_4bit_ctrl;
  import counter_4bit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  counter_4bit_ctrl_if #(.WIDTH(4)) bus ();

  counter_4bit_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raises clk_div right after edge E and drops it after edge E+2; returns on the falling edge after E+3.
  task automatic div_step();
    bus.clk_div = 1'b1;
    cyc(2);
    bus.clk_div = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_btn(input int idx);
    case (idx)
      0: bus.btn_run  = 1'b1;
      1: bus.btn_dir  = 1'b1;
      2: bus.btn_clr  = 1'b1;
      default: bus.btn_load = 1'b1;
    endcase
    cyc(8);
    bus.btn_run = 1'b0; bus.btn_dir = 1'b0; bus.btn_clr = 1'b0; bus.btn_load = 1'b0;
    cyc(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.clk_div = 1'b0; bus.btn_run = 1'b0; bus.btn_dir = 1'b0;
    bus.btn_clr = 1'b0; bus.btn_load = 1'b0; bus.sw_val = 4'd14;
    cyc(3);
    checks++; if (bus.count !== 4'd0)  begin fails++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.tc !== 1'b0)      begin fails++; $display("FAIL reset_tc got=%b exp=0", bus.tc); end
    checks++; if (bus.running !== 1'b0) begin fails++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.dir !== 1'b0)     begin fails++; $display("FAIL reset_dir got=%b exp=0", bus.dir); end
    rst = 1'b0;
  endtask

  task automatic test_run();
    bus.btn_run = 1'b1;
    cyc(6);
    @(negedge clk);
    checks++; if (bus.running !== 1'b0) begin fails++; $display("FAIL run_early got=%b exp=0", bus.running); end
    @(negedge clk);
    checks++; if (bus.running !== 1'b1) begin fails++; $display("FAIL run_accept got=%b exp=1", bus.running); end
    cyc(1);
    bus.btn_run = 1'b0;
    cyc(8);
    checks++; if (bus.running !== 1'b1) begin fails++; $display("FAIL run_release got=%b exp=1", bus.running); end
    bus.clk_div = 1'b1;
    cyc(2);
    bus.clk_div = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== 4'd0) begin fails++; $display("FAIL run_latency got=%0d exp=0", bus.count); end
    @(negedge clk);
    checks++; if (bus.count !== 4'd1) begin fails++; $display("FAIL run_step1 got=%0d exp=1", bus.count); end
    cyc(1);
    div_step();
    checks++; if (bus.count !== 4'd2) begin fails++; $display("FAIL run_step2 got=%0d exp=2", bus.count); end
    cyc(1);
    div_step();
    checks++; if (bus.count !== 4'd3 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL run_step3 got=%0d/%b exp=3/0", bus.count, bus.tc);
    end
    cyc(1);
  endtask

  task automatic test_load_wrap_up();
    press_btn(3);
    checks++; if (bus.count !== 4'd14) begin fails++; $display("FAIL load14 got=%0d exp=14", bus.count); end
    div_step();
    checks++; if (bus.count !== 4'd15 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL up15 got=%0d/%b exp=15/0", bus.count, bus.tc);
    end
    cyc(1);
    div_step();
    checks++; if (bus.count !== 4'd0 || bus.tc !== 1'b1) begin
      fails++; $display("FAIL upwrap got=%0d/%b exp=0/1", bus.count, bus.tc);
    end
    @(negedge clk);
    checks++; if (bus.tc !== 1'b0) begin fails++; $display("FAIL upwrap_tc_len got=%b exp=0", bus.tc); end
    cyc(1);
  endtask

  task automatic test_dir_wrap_down();
    div_step();
    checks++; if (bus.count !== 4'd1) begin fails++; $display("FAIL pre_dir got=%0d exp=1", bus.count); end
    cyc(1);
    press_btn(1);
    checks++; if (bus.dir !== 1'b1 || bus.count !== 4'd1) begin
      fails++; $display("FAIL dir_toggle got=%b/%0d exp=1/1", bus.dir, bus.count);
    end
    div_step();
    checks++; if (bus.count !== 4'd0 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL down0 got=%0d/%b exp=0/0", bus.count, bus.tc);
    end
    cyc(1);
    div_step();
    checks++; if (bus.count !== 4'd15 || bus.tc !== 1'b1) begin
      fails++; $display("FAIL downwrap got=%0d/%b exp=15/1", bus.count, bus.tc);
    end
    @(negedge clk);
    checks++; if (bus.tc !== 1'b0) begin fails++; $display("FAIL downwrap_tc_len got=%b exp=0", bus.tc); end
    cyc(1);
    div_step();
    checks++; if (bus.count !== 4'd14) begin fails++; $display("FAIL down14 got=%0d exp=14", bus.count); end
    cyc(1);
  endtask

  task automatic test_bounce_clear();
    for (int i = 0; i < 6; i++) begin
      bus.btn_clr = ~bus.btn_clr;
      cyc(2);
    end
    checks++; if (bus.count !== 4'd14) begin fails++; $display("FAIL bounce_noclr got=%0d exp=14", bus.count); end
    div_step();
    checks++; if (bus.count !== 4'd13) begin fails++; $display("FAIL bounce_step got=%0d exp=13", bus.count); end
    cyc(1);
    bus.btn_clr = 1'b1;
    cyc(7);
    checks++; if (bus.count !== 4'd0 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL clr got=%0d/%b exp=0/0", bus.count, bus.tc);
    end
    cyc(1);
    bus.btn_clr = 1'b0;
    cyc(8);
    checks++; if (bus.running !== 1'b1 || bus.dir !== 1'b1) begin
      fails++; $display("FAIL clr_state got=%b/%b exp=1/1", bus.running, bus.dir);
    end
  endtask

  task automatic test_back_to_back();
    press_btn(1);
    bus.sw_val = 4'd15;
    cyc(3);
    bus.btn_load = 1'b1;
    cyc(7);
    checks++; if (bus.count !== 4'd15 || bus.tc !== 1'b0 || bus.dir !== 1'b0) begin
      fails++; $display("FAIL load15 got=%0d/%b/%b exp=15/0/0", bus.count, bus.tc, bus.dir);
    end
    cyc(1);
    bus.btn_load = 1'b0;
    cyc(8);
    // The clear is accepted at the same edge as a wrapping up-step.
    bus.btn_clr = 1'b1;
    cyc(4);
    bus.clk_div = 1'b1;
    cyc(2);
    bus.clk_div = 1'b0;
    cyc(1);
    checks++; if (bus.count !== 4'd0 || bus.tc !== 1'b0 || bus.running !== 1'b1) begin
      fails++; $display("FAIL clr_vs_step got=%0d/%b/%b exp=0/0/1", bus.count, bus.tc, bus.running);
    end
    cyc(1);
    bus.btn_clr = 1'b0;
    cyc(8);
    bus.btn_run = 1'b1;
    cyc(4);
    bus.clk_div = 1'b1;
    cyc(2);
    bus.clk_div = 1'b0;
    cyc(1);
    checks++; if (bus.count !== 4'd1 || bus.running !== 1'b0) begin
      fails++; $display("FAIL run_vs_step got=%0d/%b exp=1/0", bus.count, bus.running);
    end
    cyc(1);
    bus.btn_run = 1'b0;
    cyc(8);
    div_step();
    checks++; if (bus.count !== 4'd1 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL paused_step got=%0d/%b exp=1/0", bus.count, bus.tc);
    end
    cyc(1);
  endtask

  task automatic test_async_reset();
    press_btn(0);
    bus.sw_val = 4'd9;
    cyc(3);
    press_btn(3);
    press_btn(1);
    checks++; if (bus.count !== 4'd9 || bus.running !== 1'b1 || bus.dir !== 1'b1) begin
      fails++; $display("FAIL pre_rst got=%0d/%b/%b exp=9/1/1", bus.count, bus.running, bus.dir);
    end
    bus.clk_div = 1'b1;
    cyc(1);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.count !== 4'd0 || bus.running !== 1'b0 || bus.dir !== 1'b0 || bus.tc !== 1'b0) begin
      fails++; $display("FAIL async_rst got=%0d/%b/%b/%b exp=0/0/0/0", bus.count, bus.running, bus.dir, bus.tc);
    end
    bus.clk_div = 1'b0;
    cyc(2);
    rst = 1'b0;
    press_btn(0);
    checks++; if (bus.count !== 4'd0 || bus.running !== 1'b1) begin
      fails++; $display("FAIL post_rst got=%0d/%b exp=0/1", bus.count, bus.running);
    end
    bus.clk_div = 1'b1;
    cyc(2);
    bus.clk_div = 1'b0;
    @(negedge clk);
    checks++; if (bus.count !== 4'd0) begin fails++; $display("FAIL post_rst_latency got=%0d exp=0", bus.count); end
    @(negedge clk);
    checks++; if (bus.count !== 4'd1) begin fails++; $display("FAIL post_rst_step got=%0d exp=1", bus.count); end
    cyc(1);
  endtask

  initial begin
    test_reset();
    test_run();
    test_load_wrap_up();
    test_dir_wrap_down();
    test_bounce_clear();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
